// File: rtl/match_pe_sb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | match_pe_sb -- DEPTH-entry scoreboard issuing PU_WIDTH-byte history compares |
// | Optional MATCH_PE_PERF_CNT_EN enables request/round counters.    Rev 1.0    |
// +-----------------------------------------------------------------------------+
module match_pe_sb #(
  parameter int DEPTH         = 4,
  parameter int PU_WIDTH      = 16,
  parameter int MAX_MATCH_LEN = 64,
  parameter int ADDR_WIDTH    = 16,
  parameter int JOB_ID_WIDTH  = 2,
  parameter int TAG_WIDTH     = 8,
  parameter int RD_LAT        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_match_req_valid,
  output logic                            o_match_req_ready,
  input  logic [JOB_ID_WIDTH-1:0]         i_match_req_job_pe_id,
  input  logic [TAG_WIDTH-1:0]            i_match_req_tag,
  input  logic [ADDR_WIDTH-1:0]           i_match_req_head_addr,
  input  logic [ADDR_WIDTH-1:0]           i_match_req_history_addr,
  output logic                            o_rd_valid,
  output logic [ADDR_WIDTH-1:0]           o_rd_head_addr,
  output logic [ADDR_WIDTH-1:0]           o_rd_history_addr,
  input  logic [PU_WIDTH*8-1:0]           i_rd_head_data,
  input  logic [PU_WIDTH*8-1:0]           i_rd_history_data,
  output logic                            o_match_resp_valid,
  input  logic                            i_match_resp_ready,
  output logic [JOB_ID_WIDTH-1:0]         o_match_resp_job_pe_id,
  output logic [TAG_WIDTH-1:0]            o_match_resp_tag,
  output logic [$clog2(MAX_MATCH_LEN):0]  o_match_resp_match_len,
  output logic [31:0]                     o_perf_req_cnt,
  output logic [31:0]                     o_perf_round_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(MAX_MATCH_LEN) + 1;
  localparam int RL_W  = $clog2(PU_WIDTH) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_MATCH_LEN);
  localparam logic [RL_W-1:0]  FULL_RND = RL_W'(PU_WIDTH);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    WAIT     = 2'd1,
    INFLIGHT = 2'd2,
    DONE     = 2'd3
  } ent_state_t;

  ent_state_t              state_q [DEPTH];
  ent_state_t              state_d [DEPTH];
  logic [JOB_ID_WIDTH-1:0] job_q   [DEPTH];
  logic [TAG_WIDTH-1:0]    tag_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]   head_q  [DEPTH];
  logic [ADDR_WIDTH-1:0]   hist_q  [DEPTH];
  logic [LEN_W-1:0]        len_q   [DEPTH];

  logic             any_free, any_wait, any_done;
  logic [IDX_W-1:0] free_idx, wait_idx, done_idx;
  logic             accept, issue, resp_fire;

  // Lowest-index picker per state: scanning downward leaves the lowest match last.
  always_comb begin
    any_free = 1'b0;
    any_wait = 1'b0;
    any_done = 1'b0;
    free_idx = '0;
    wait_idx = '0;
    done_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (state_q[i] == WAIT) begin
        any_wait = 1'b1;
        wait_idx = IDX_W'(i);
      end
      if (state_q[i] == DONE) begin
        any_done = 1'b1;
        done_idx = IDX_W'(i);
      end
    end
  end

  // Entries are all FREE while in reset, so ready is explicitly held low there.
  assign o_match_req_ready = rst_n & any_free;
  assign accept            = i_match_req_valid & o_match_req_ready;
  assign issue             = any_wait;
  assign resp_fire         = any_done & i_match_resp_ready;

  assign o_rd_valid        = issue;
  assign o_rd_head_addr    = issue ? head_q[wait_idx] + ADDR_WIDTH'(len_q[wait_idx]) : '0;
  assign o_rd_history_addr = issue ? hist_q[wait_idx] + ADDR_WIDTH'(len_q[wait_idx]) : '0;

  assign o_match_resp_valid     = any_done;
  assign o_match_resp_job_pe_id = any_done ? job_q[done_idx] : '0;
  assign o_match_resp_tag       = any_done ? tag_q[done_idx] : '0;
  assign o_match_resp_match_len = any_done ? len_q[done_idx] : '0;

  logic             pipe_vld [RD_LAT];
  logic [IDX_W-1:0] pipe_idx [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_idx[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue;
      pipe_idx[0] <= wait_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
    end
  end

  logic [RL_W-1:0] rnd_len;
  logic            run;

  always_comb begin
    rnd_len = '0;
    run     = 1'b1;
    for (int k = 0; k < PU_WIDTH; k++) begin
      if (run && (i_rd_head_data[8*k +: 8] == i_rd_history_data[8*k +: 8])) begin
        rnd_len = rnd_len + RL_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  logic             res_vld;
  logic [IDX_W-1:0] res_idx;
  logic [RL_W-1:0]  res_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld <= 1'b0;
      res_idx <= '0;
      res_len <= '0;
    end else begin
      res_vld <= pipe_vld[RD_LAT-1];
      res_idx <= pipe_idx[RD_LAT-1];
      res_len <= rnd_len;
    end
  end

  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_new;
  logic             go_again;

  always_comb begin
    len_sum  = {1'b0, len_q[res_idx]} + (LEN_W+1)'(res_len);
    len_new  = (len_sum > {1'b0, MAX_LEN}) ? MAX_LEN : len_sum[LEN_W-1:0];
    go_again = (res_len == FULL_RND) && (len_new < MAX_LEN);
  end

  // The four events always target distinct entries since each needs a different state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
    end
    if (accept) begin
      state_d[free_idx] = WAIT;
    end
    if (issue) begin
      state_d[wait_idx] = INFLIGHT;
    end
    if (res_vld) begin
      state_d[res_idx] = go_again ? WAIT : DONE;
    end
    if (resp_fire) begin
      state_d[done_idx] = FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        job_q[i]  <= '0;
        tag_q[i]  <= '0;
        head_q[i] <= '0;
        hist_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        job_q[free_idx]  <= i_match_req_job_pe_id;
        tag_q[free_idx]  <= i_match_req_tag;
        head_q[free_idx] <= i_match_req_head_addr;
        hist_q[free_idx] <= i_match_req_history_addr;
        len_q[free_idx]  <= '0;
      end
      if (res_vld) begin
        len_q[res_idx] <= len_new;
      end
    end
  end

`ifdef MATCH_PE_PERF_CNT_EN
  logic [31:0] req_cnt;
  logic [31:0] round_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt   <= '0;
      round_cnt <= '0;
    end else begin
      req_cnt   <= req_cnt + 32'(accept);
      round_cnt <= round_cnt + 32'(issue);
    end
  end

  assign o_perf_req_cnt   = req_cnt;
  assign o_perf_round_cnt = round_cnt;
`else
  assign o_perf_req_cnt   = '0;
  assign o_perf_round_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_match_pe_sb.sv
`default_nettype none
// tb_match_pe_sb: directed scenarios checked every cycle against a request-level model
// (expected lengths come from a synthetic head/history memory with planted byte flips).
module tb_match_pe_sb;
  localparam int DEPTH  = 4;
  localparam int PU     = 16;
  localparam int MAXL   = 64;
  localparam int AW     = 16;
  localparam int JW     = 2;
  localparam int TW     = 8;
  localparam int RD_LAT = 2;
  localparam int LW     = $clog2(MAXL) + 1;
  localparam logic [15:0] D = 16'h1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [JW-1:0]   req_job = '0;
  logic [TW-1:0]   req_tag = '0;
  logic [AW-1:0]   req_head = '0;
  logic [AW-1:0]   req_hist = '0;
  logic            rd_valid;
  logic [AW-1:0]   rd_head, rd_hist;
  logic [PU*8-1:0] rd_head_data = '0;
  logic [PU*8-1:0] rd_hist_data = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [JW-1:0]   resp_job;
  logic [TW-1:0]   resp_tag;
  logic [LW-1:0]   resp_len;
  logic [31:0]     perf_req, perf_round;

  always #5 clk = ~clk;

  match_pe_sb #(
    .DEPTH(DEPTH), .PU_WIDTH(PU), .MAX_MATCH_LEN(MAXL), .ADDR_WIDTH(AW),
    .JOB_ID_WIDTH(JW), .TAG_WIDTH(TW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_match_req_valid(req_valid), .o_match_req_ready(req_ready),
    .i_match_req_job_pe_id(req_job), .i_match_req_tag(req_tag),
    .i_match_req_head_addr(req_head), .i_match_req_history_addr(req_hist),
    .o_rd_valid(rd_valid), .o_rd_head_addr(rd_head), .o_rd_history_addr(rd_hist),
    .i_rd_head_data(rd_head_data), .i_rd_history_data(rd_hist_data),
    .o_match_resp_valid(resp_valid), .i_match_resp_ready(resp_ready),
    .o_match_resp_job_pe_id(resp_job), .o_match_resp_tag(resp_tag),
    .o_match_resp_match_len(resp_len),
    .o_perf_req_cnt(perf_req), .o_perf_round_cnt(perf_round)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s", msg);
  endtask

  // Synthetic memories: history at a+D mirrors head at a, except at flipped addresses.
  bit corrupt [int];

  function automatic logic [7:0] head_byte(input logic [15:0] a);
    return (a[7:0] ^ 8'h5A) + a[15:8];
  endfunction

  function automatic logic [7:0] hist_byte(input logic [15:0] a);
    logic [15:0] s;
    logic [7:0]  b;
    s = a - D;
    b = head_byte(s);
    return corrupt.exists(int'(a)) ? ~b : b;
  endfunction

  function automatic int exp_len(input logic [15:0] h, input logic [15:0] y);
    for (int n = 0; n < MAXL; n++) begin
      if (head_byte(h + 16'(n)) != hist_byte(y + 16'(n))) return n;
    end
    return MAXL;
  endfunction

  // Read-data responder: data for a read seen in cycle t appears in cycle t+RD_LAT.
  logic [15:0] cap_h [RD_LAT+1] = '{default: 16'h0};
  logic [15:0] cap_y [RD_LAT+1] = '{default: 16'h0};
  always @(negedge clk) begin
    for (int j = RD_LAT; j > 0; j--) begin
      cap_h[j] = cap_h[j-1];
      cap_y[j] = cap_y[j-1];
    end
    cap_h[0] = rd_head;
    cap_y[0] = rd_hist;
    for (int k = 0; k < PU; k++) begin
      rd_head_data[8*k +: 8] = head_byte(cap_h[RD_LAT] + 16'(k));
      rd_hist_data[8*k +: 8] = hist_byte(cap_y[RD_LAT] + 16'(k));
    end
  end

  typedef struct {
    logic [JW-1:0] job;
    logic [TW-1:0] tag;
    logic [15:0]   h;
    logic [15:0]   y;
    int            len;
    int            rounds;
    int            issued;
  } rec_t;

  rec_t outq[$];
  int   n_acc = 0;
  int   n_rounds = 0;
  int   acc_cyc[$], acc_tags[$], resp_cyc[$], resp_tags[$], resp_lens[$], rd_log[$];

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_tags.delete(); resp_cyc.delete();
    resp_tags.delete(); resp_lens.delete(); rd_log.delete();
  endtask

  always @(negedge clk) begin : compare
    rec_t r;
    int   hit;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rd_addrs", 64'({rd_head, rd_hist}), 64'd0);
      chk("rst_resp_fields", 64'({resp_job, resp_tag, resp_len}), 64'd0);
      chk("rst_perf", 64'({perf_req, perf_round}), 64'd0);
      outq.delete();
      n_acc = 0;
      n_rounds = 0;
    end else begin
      chk("req_ready", 64'(req_ready), 64'(outq.size() < DEPTH));
`ifdef MATCH_PE_PERF_CNT_EN
      chk("perf_req", 64'(perf_req), 64'(n_acc));
      chk("perf_round", 64'(perf_round), 64'(n_rounds));
`else
      chk("perf_req", 64'(perf_req), 64'd0);
      chk("perf_round", 64'(perf_round), 64'd0);
`endif
      if (rd_valid) begin
        hit = -1;
        foreach (outq[i]) begin
          if (hit < 0 && outq[i].issued < outq[i].rounds &&
              outq[i].h + 16'(PU * outq[i].issued) == rd_head &&
              outq[i].y + 16'(PU * outq[i].issued) == rd_hist) hit = i;
        end
        vectors++;
        if (hit < 0) begin
          miscompares++;
          $display("FAIL rd_addr: got head 0x%0h hist 0x%0h, expected a pending round address", rd_head, rd_hist);
        end else begin
          outq[hit].issued++;
        end
        n_rounds++;
        rd_log.push_back(int'(rd_head));
      end
      if (resp_valid && resp_ready) begin
        hit = -1;
        foreach (outq[i]) if (hit < 0 && outq[i].tag == resp_tag) hit = i;
        if (hit < 0) begin
          fail($sformatf("resp_tag: got unexpected tag 0x%0h, expected no response", resp_tag));
        end else begin
          chk("resp_job", 64'(resp_job), 64'(outq[hit].job));
          chk("resp_len", 64'(resp_len), 64'(outq[hit].len));
          chk("resp_rounds", 64'(outq[hit].issued), 64'(outq[hit].rounds));
          outq.delete(hit);
        end
        resp_cyc.push_back(cyc);
        resp_tags.push_back(int'(resp_tag));
        resp_lens.push_back(int'(resp_len));
      end
      if (req_valid && req_ready) begin
        r.job = req_job;
        r.tag = req_tag;
        r.h = req_head;
        r.y = req_hist;
        r.len = exp_len(req_head, req_hist);
        r.rounds = (r.len == MAXL) ? MAXL / PU : r.len / PU + 1;
        r.issued = 0;
        outq.push_back(r);
        n_acc++;
        acc_cyc.push_back(cyc);
        acc_tags.push_back(int'(req_tag));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [JW-1:0] job, input logic [TW-1:0] tag, input logic [15:0] h);
    req_valid = 1'b1;
    req_job = job;
    req_tag = tag;
    req_head = h;
    req_hist = h + D;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    fail($sformatf("send_timeout: tag 0x%0h not accepted within 200 cycles", tag));
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (outq.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (outq.size() != 0) fail($sformatf("%s: %0d requests still pending after %0d cycles", name, outq.size(), budget));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single request, history differs at byte 5.
    corrupt.delete(); clear_logs(); resp_ready = 1'b1;
    corrupt[int'(16'h1105)] = 1'b1;
    chk("t1_model_len", 64'(exp_len(16'h0100, 16'h1100)), 64'd5);
    send(2'd1, 8'h11, 16'h0100);
    wait_idle("t1_idle", 50);
    chk("t1_len", 64'(at(resp_lens, 0)), 64'd5);
    chk("t1_latency", 64'(at(resp_cyc, 0) - at(acc_cyc, 0)), 64'(RD_LAT + 3));
    chk("t1_reads", 64'(rd_log.size()), 64'd1);
    chk("t1_rd_addr", 64'(at(rd_log, 0)), 64'h0100);

    // Full-length match: four rounds at +0/16/32/48.
    corrupt.delete(); clear_logs();
    send(2'd2, 8'h22, 16'h0200);
    wait_idle("t2_idle", 100);
    chk("t2_len", 64'(at(resp_lens, 0)), 64'd64);
    chk("t2_reads", 64'(rd_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t2_rd_addr", 64'(at(rd_log, i)), 64'(16'h0200 + 16'(16 * i)));

    // Five back-to-back requests with responses stalled.
    corrupt.delete(); clear_logs(); resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) corrupt[int'(D + 16'h0300 + 16'(i * 64) + 16'd3)] = 1'b1;
    for (int i = 0; i < 4; i++) send(2'(i), 8'(8'h30 + i), 16'h0300 + 16'(i * 64));
    req_valid = 1'b1; req_job = 2'd0; req_tag = 8'h34; req_head = 16'h0400; req_hist = 16'h1400;
    tick(20);
    chk("t3_held_accepts", 64'(acc_tags.size()), 64'd4);
    chk("t3_ready_low", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    tick(1);
    req_valid = 1'b0;
    chk("t3_first_drain_tag", 64'(at(resp_tags, 0)), 64'h30);
    chk("t3_accept_after_drain", 64'(at(acc_cyc, 4) - at(resp_cyc, 0)), 64'd1);
    resp_ready = 1'b1;
    wait_idle("t3_idle", 200);
    chk("t3_resp_count", 64'(resp_tags.size()), 64'd5);

    // Long match on entry 0, immediate mismatch on entry 1.
    corrupt.delete(); clear_logs();
    corrupt[int'(16'h1500 + 16'd40)] = 1'b1;
    corrupt[int'(16'h1600)] = 1'b1;
    chk("t4_model_len", 64'(exp_len(16'h0500, 16'h1500)), 64'd40);
    send(2'd0, 8'h41, 16'h0500);
    send(2'd1, 8'h42, 16'h0600);
    wait_idle("t4_idle", 100);
    chk("t4_first_tag", 64'(at(resp_tags, 0)), 64'h42);
    chk("t4_first_len", 64'(at(resp_lens, 0)), 64'd0);
    chk("t4_second_tag", 64'(at(resp_tags, 1)), 64'h41);
    chk("t4_second_len", 64'(at(resp_lens, 1)), 64'd40);

    // Response and request in the same cycle with one FREE entry.
    corrupt.delete(); clear_logs(); resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) corrupt[int'(D + 16'h0700 + 16'(i * 64) + 16'd2)] = 1'b1;
    for (int i = 0; i < 3; i++) send(2'(i), 8'(8'h51 + i), 16'h0700 + 16'(i * 64));
    tick(15);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_job = 2'd3; req_tag = 8'h54; req_head = 16'h07C0; req_hist = 16'h17C0;
    tick(1);
    resp_ready = 1'b0;
    req_job = 2'd0; req_tag = 8'h55; req_head = 16'h0800; req_hist = 16'h1800;
    tick(1);
    req_valid = 1'b0;
    chk("t5_same_cycle", 64'(at(acc_cyc, 3) - at(resp_cyc, 0)), 64'd0);
    chk("t5_first_resp_tag", 64'(at(resp_tags, 0)), 64'h51);
    chk("t5_reuse_next_cycle", 64'(at(acc_cyc, 4) - at(acc_cyc, 3)), 64'd1);
    chk("t5_reuse_tag", 64'(at(acc_tags, 4)), 64'h55);
    resp_ready = 1'b1;
    wait_idle("t5_idle", 200);

    // Asynchronous reset with two entries in flight.
    corrupt.delete(); clear_logs(); resp_ready = 1'b0;
    send(2'd0, 8'h61, 16'h0900);
    send(2'd1, 8'h62, 16'h0A00);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ready_now", 64'(req_ready), 64'd0);
    chk("t6_rd_valid_now", 64'(rd_valid), 64'd0);
    chk("t6_resp_valid_now", 64'(resp_valid), 64'd0);
    chk("t6_perf_now", 64'({perf_req, perf_round}), 64'd0);
    tick(3);
    rst_n = 1'b1;
    clear_logs();
    resp_ready = 1'b1;
    tick(30);
    chk("t6_no_resp", 64'(resp_tags.size()), 64'd0);
    chk("t6_no_reads", 64'(rd_log.size()), 64'd0);
    chk("t6_perf_after", 64'({perf_req, perf_round}), 64'd0);

    // Normal operation after reset: mismatch at byte 17, two rounds.
    corrupt.delete(); clear_logs();
    corrupt[int'(16'h1B00 + 16'd17)] = 1'b1;
    send(2'd3, 8'h71, 16'h0B00);
    wait_idle("t7_idle", 100);
    chk("t7_len", 64'(at(resp_lens, 0)), 64'd17);
    chk("t7_reads", 64'(rd_log.size()), 64'd2);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
